// File: rtl/axi_lite_pz_master_if.sv
// AXI4-Lite bus bundle between the pole/zero command master and the register-file slave.
interface axi_lite_pz_master_if #(
  parameter int unsigned AXI_LITE_ADDR_WIDTH = 8
);
  logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_awaddr;
  logic                           m_axi_lite_awvalid;
  logic                           m_axi_lite_awready;
  logic [31:0]                    m_axi_lite_wdata;
  logic [3:0]                     m_axi_lite_wstrb;
  logic                           m_axi_lite_wvalid;
  logic                           m_axi_lite_wready;
  logic [1:0]                     m_axi_lite_bresp;
  logic                           m_axi_lite_bvalid;
  logic                           m_axi_lite_bready;
  logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_araddr;
  logic                           m_axi_lite_arvalid;
  logic                           m_axi_lite_arready;
  logic [31:0]                    m_axi_lite_rdata;
  logic [1:0]                     m_axi_lite_rresp;
  logic                           m_axi_lite_rvalid;
  logic                           m_axi_lite_rready;

  modport master (
    output m_axi_lite_awaddr, m_axi_lite_awvalid, m_axi_lite_wdata, m_axi_lite_wstrb,
           m_axi_lite_wvalid, m_axi_lite_bready, m_axi_lite_araddr, m_axi_lite_arvalid,
           m_axi_lite_rready,
    input  m_axi_lite_awready, m_axi_lite_wready, m_axi_lite_bresp, m_axi_lite_bvalid,
           m_axi_lite_arready, m_axi_lite_rdata, m_axi_lite_rresp, m_axi_lite_rvalid
  );

  modport slave (
    input  m_axi_lite_awaddr, m_axi_lite_awvalid, m_axi_lite_wdata, m_axi_lite_wstrb,
           m_axi_lite_wvalid, m_axi_lite_bready, m_axi_lite_araddr, m_axi_lite_arvalid,
           m_axi_lite_rready,
    output m_axi_lite_awready, m_axi_lite_wready, m_axi_lite_bresp, m_axi_lite_bvalid,
           m_axi_lite_arready, m_axi_lite_rdata, m_axi_lite_rresp, m_axi_lite_rvalid
  );
endinterface

// File: rtl/axi_lite_pz_master.sv
// Single-outstanding AXI4-Lite initiator turning cmd/rsp requests into pole/zero register
// accesses, with a per-transaction timeout so a dead slave cannot stall the requester.
module axi_lite_pz_master #(
  parameter int unsigned AXI_LITE_ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT_CYCLES      = 1024
) (
  input  logic                           m_axi_lite_aclk,
  input  logic                           axi_reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_write,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]                    cmd_wdata,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_rdata,
  output logic [1:0]                     rsp_resp,
  output logic                           rsp_timeout,
  axi_lite_pz_master_if.master           axi
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RESP_W  = 2;
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_AW_W,
    S_WR_B,
    S_RD_AR,
    S_RD_R,
    S_RESP
  } state_e;

  state_e                         state_q;
  logic [AXI_LITE_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_W-1:0]              wdata_q;
  logic                           awvalid_q;
  logic                           wvalid_q;
  logic                           bready_q;
  logic                           arvalid_q;
  logic                           rready_q;
  logic                           rsp_valid_q;
  logic [DATA_W-1:0]              rsp_rdata_q;
  logic [RESP_W-1:0]              rsp_resp_q;
  logic                           rsp_timeout_q;
  logic [CNT_W-1:0]               tmo_cnt_q;

  logic active_c;
  logic tmo_hit_c;
  logic aw_done_c;
  logic w_done_c;

  // Timeout budget only runs while the bus side owns the transaction.
  assign active_c  = (state_q != S_IDLE) && (state_q != S_RESP);
  assign tmo_hit_c = (TIMEOUT_CYCLES != 0) && active_c && (tmo_cnt_q == CNT_W'(TO_LAST));
  assign aw_done_c = !awvalid_q || axi.m_axi_lite_awready;
  assign w_done_c  = !wvalid_q  || axi.m_axi_lite_wready;

  assign cmd_ready   = (state_q == S_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;

  assign axi.m_axi_lite_awaddr  = addr_q;
  assign axi.m_axi_lite_araddr  = addr_q;
  assign axi.m_axi_lite_wdata   = wdata_q;
  assign axi.m_axi_lite_wstrb   = 4'b1111;
  assign axi.m_axi_lite_awvalid = awvalid_q;
  assign axi.m_axi_lite_wvalid  = wvalid_q;
  assign axi.m_axi_lite_bready  = bready_q;
  assign axi.m_axi_lite_arvalid = arvalid_q;
  assign axi.m_axi_lite_rready  = rready_q;

  always_ff @(posedge m_axi_lite_aclk) begin
    if (axi_reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      if (active_c && (TIMEOUT_CYCLES != 0)) begin
        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      end

      // Timeout abandons whatever phase is pending and reports SLVERR.
      if (tmo_hit_c) begin
        awvalid_q     <= 1'b0;
        wvalid_q      <= 1'b0;
        bready_q      <= 1'b0;
        arvalid_q     <= 1'b0;
        rready_q      <= 1'b0;
        rsp_valid_q   <= 1'b1;
        rsp_rdata_q   <= '0;
        rsp_resp_q    <= RESP_SLVERR;
        rsp_timeout_q <= 1'b1;
        state_q       <= S_RESP;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cmd_valid) begin
              tmo_cnt_q <= '0;
              addr_q    <= cmd_addr;
              if (cmd_write) begin
                wdata_q   <= cmd_wdata;
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                state_q   <= S_WR_AW_W;
              end else begin
                arvalid_q <= 1'b1;
                state_q   <= S_RD_AR;
              end
            end
          end

          // AW and W retire independently; B is opened once both have gone.
          S_WR_AW_W: begin
            if (axi.m_axi_lite_awready) begin
              awvalid_q <= 1'b0;
            end
            if (axi.m_axi_lite_wready) begin
              wvalid_q <= 1'b0;
            end
            if (aw_done_c && w_done_c) begin
              bready_q <= 1'b1;
              state_q  <= S_WR_B;
            end
          end

          S_WR_B: begin
            if (axi.m_axi_lite_bvalid) begin
              bready_q      <= 1'b0;
              rsp_valid_q   <= 1'b1;
              rsp_rdata_q   <= '0;
              rsp_resp_q    <= axi.m_axi_lite_bresp;
              rsp_timeout_q <= 1'b0;
              state_q       <= S_RESP;
            end
          end

          S_RD_AR: begin
            if (axi.m_axi_lite_arready) begin
              arvalid_q <= 1'b0;
              rready_q  <= 1'b1;
              state_q   <= S_RD_R;
            end
          end

          S_RD_R: begin
            if (axi.m_axi_lite_rvalid) begin
              rready_q      <= 1'b0;
              rsp_valid_q   <= 1'b1;
              rsp_rdata_q   <= axi.m_axi_lite_rdata;
              rsp_resp_q    <= axi.m_axi_lite_rresp;
              rsp_timeout_q <= 1'b0;
              state_q       <= S_RESP;
            end
          end

          S_RESP: begin
            if (rsp_ready) begin
              rsp_valid_q <= 1'b0;
              state_q     <= S_IDLE;
            end
          end

          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_pz_master.sv
// Directed bench for axi_lite_pz_master: a latency-programmable slave, a transaction-level
// reference model compared every cycle, and hand-computed literal expectations per scenario.
module tb_axi_lite_pz_master;

  localparam int unsigned AW = 8;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          axi_reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;

  axi_lite_pz_master_if #(.AXI_LITE_ADDR_WIDTH(AW)) bus ();

  axi_lite_pz_master #(
    .AXI_LITE_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES     (TO)
  ) dut (
    .m_axi_lite_aclk(clk),
    .axi_reset      (axi_reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_resp       (rsp_resp),
    .rsp_timeout    (rsp_timeout),
    .axi            (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Slave knobs: cycles of waiting before ready/valid answers; negative means never.
  int          aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  logic [1:0]  slv_bresp = 2'b00, slv_rresp = 2'b00;
  logic [31:0] slv_rdata = 32'h0;

  initial begin
    int aw_c, w_c, b_c, ar_c, r_c;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
    bus.m_axi_lite_awready = 1'b0;
    bus.m_axi_lite_wready  = 1'b0;
    bus.m_axi_lite_bvalid  = 1'b0;
    bus.m_axi_lite_bresp   = 2'b00;
    bus.m_axi_lite_arready = 1'b0;
    bus.m_axi_lite_rvalid  = 1'b0;
    bus.m_axi_lite_rdata   = 32'h0;
    bus.m_axi_lite_rresp   = 2'b00;
    forever begin
      @(negedge clk);
      aw_c = (bus.m_axi_lite_awvalid === 1'b1) ? aw_c + 1 : 0;
      w_c  = (bus.m_axi_lite_wvalid  === 1'b1) ? w_c + 1  : 0;
      b_c  = (bus.m_axi_lite_bready  === 1'b1) ? b_c + 1  : 0;
      ar_c = (bus.m_axi_lite_arvalid === 1'b1) ? ar_c + 1 : 0;
      r_c  = (bus.m_axi_lite_rready  === 1'b1) ? r_c + 1  : 0;
      bus.m_axi_lite_awready = (aw_c > 0) && (aw_lat >= 0) && (aw_c > aw_lat);
      bus.m_axi_lite_wready  = (w_c  > 0) && (w_lat  >= 0) && (w_c  > w_lat);
      bus.m_axi_lite_bvalid  = (b_c  > 0) && (b_lat  >= 0) && (b_c  > b_lat);
      bus.m_axi_lite_arready = (ar_c > 0) && (ar_lat >= 0) && (ar_c > ar_lat);
      bus.m_axi_lite_rvalid  = (r_c  > 0) && (r_lat  >= 0) && (r_c  > r_lat);
      bus.m_axi_lite_bresp   = slv_bresp;
      bus.m_axi_lite_rresp   = slv_rresp;
      bus.m_axi_lite_rdata   = slv_rdata;
    end
  end

  int b_hs = 0;
  always @(posedge clk) begin
    if (axi_reset === 1'b0 && bus.m_axi_lite_bvalid && bus.m_axi_lite_bready === 1'b1) b_hs++;
  end

  // Transaction-level model: pending phase flags plus an age counter for the timeout.
  logic          m_busy, m_wr, m_aw, m_w, m_b, m_ar, m_r, m_rsp, m_to;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata, m_rdata;
  logic [1:0]    m_resp;
  int            m_age;

  initial begin
    m_busy = 0; m_wr = 0; m_aw = 0; m_w = 0; m_b = 0; m_ar = 0; m_r = 0;
    m_rsp = 0; m_to = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_resp = '0; m_age = 0;
    forever begin
      @(posedge clk);
      if (axi_reset) begin
        m_busy = 0; m_aw = 0; m_w = 0; m_b = 0; m_ar = 0; m_r = 0; m_rsp = 0;
        m_to = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_resp = '0;
      end else if (m_rsp) begin
        if (rsp_ready) m_rsp = 0;
      end else if (!m_busy) begin
        if (cmd_valid) begin
          m_busy = 1; m_age = 0; m_wr = cmd_write; m_addr = cmd_addr;
          if (cmd_write) begin
            m_wdata = cmd_wdata; m_aw = 1; m_w = 1;
          end else begin
            m_ar = 1;
          end
        end
      end else begin
        m_age++;
        if (m_age == int'(TO)) begin
          m_aw = 0; m_w = 0; m_b = 0; m_ar = 0; m_r = 0; m_busy = 0;
          m_rsp = 1; m_resp = 2'b10; m_rdata = 0; m_to = 1;
        end else if (m_b && bus.m_axi_lite_bvalid) begin
          m_b = 0; m_busy = 0; m_rsp = 1; m_resp = bus.m_axi_lite_bresp; m_rdata = 0; m_to = 0;
        end else if (m_r && bus.m_axi_lite_rvalid) begin
          m_r = 0; m_busy = 0; m_rsp = 1; m_resp = bus.m_axi_lite_rresp;
          m_rdata = bus.m_axi_lite_rdata; m_to = 0;
        end else if (m_ar && bus.m_axi_lite_arready) begin
          m_ar = 0; m_r = 1;
        end else if (m_aw || m_w) begin
          if (bus.m_axi_lite_awready) m_aw = 0;
          if (bus.m_axi_lite_wready) m_w = 0;
          if (!m_aw && !m_w) m_b = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy && !m_rsp));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
      chk("awvalid", 32'(bus.m_axi_lite_awvalid), 32'(m_aw));
      chk("wvalid", 32'(bus.m_axi_lite_wvalid), 32'(m_w));
      chk("bready", 32'(bus.m_axi_lite_bready), 32'(m_b));
      chk("arvalid", 32'(bus.m_axi_lite_arvalid), 32'(m_ar));
      chk("rready", 32'(bus.m_axi_lite_rready), 32'(m_r));
      chk("wstrb", 32'(bus.m_axi_lite_wstrb), 32'hF);
      if (m_aw) chk("awaddr", 32'(bus.m_axi_lite_awaddr), 32'(m_addr));
      if (m_w)  chk("wdata", bus.m_axi_lite_wdata, m_wdata);
      if (m_ar) chk("araddr", 32'(bus.m_axi_lite_araddr), 32'(m_addr));
      if (m_rsp) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_resp", 32'(rsp_resp), 32'(m_resp));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(m_to));
      end
    end
  end

  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    while (cmd_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 32'(cmd_ready), 32'h1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] rd, output logic [1:0] rs, output logic to,
                          output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_arrive", 32'(rsp_valid), 32'h1);
    rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
    if (rsp_ready) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        to;
    int          n, b0;
    axi_reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    check_en = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_awaddr", 32'(bus.m_axi_lite_awaddr), 32'h0);
    chk("reset_wdata", bus.m_axi_lite_wdata, 32'h0);
    @(negedge clk);
    axi_reset = 1'b0;

    // Always-ready write
    send_cmd(1'b1, 8'h04, 32'h0010FFF0);
    chk("wr_awvalid", 32'(bus.m_axi_lite_awvalid), 32'h1);
    chk("wr_awaddr", 32'(bus.m_axi_lite_awaddr), 32'h04);
    chk("wr_wdata", bus.m_axi_lite_wdata, 32'h0010FFF0);
    wait_rsp(rd, rs, to, n);
    chk("wr_latency", 32'(n), 32'd2);
    chk("wr_resp", 32'(rs), 32'h0);
    chk("wr_rdata", rd, 32'h0);

    // Skewed write: W ready immediately, AW ready three cycles later
    aw_lat = 3; b0 = b_hs;
    send_cmd(1'b1, 8'h10, 32'hA5A50001);
    wait_rsp(rd, rs, to, n);
    chk("skew_latency", 32'(n), 32'd5);
    chk("skew_resp", 32'(rs), 32'h0);
    repeat (2) @(negedge clk);
    chk("skew_b_count", 32'(b_hs - b0), 32'd1);
    aw_lat = 0;

    // Write answered with SLVERR
    slv_bresp = 2'b10;
    send_cmd(1'b1, 8'h0C, 32'h00000001);
    wait_rsp(rd, rs, to, n);
    chk("slverr_resp", 32'(rs), 32'h2);
    chk("slverr_timeout", 32'(to), 32'h0);
    slv_bresp = 2'b00;

    // Read with 5 wait cycles on R
    r_lat = 5; slv_rdata = 32'hDEADBEEF;
    send_cmd(1'b0, 8'h08, 32'h0);
    chk("rd_araddr", 32'(bus.m_axi_lite_araddr), 32'h08);
    wait_rsp(rd, rs, to, n);
    chk("rd_latency", 32'(n), 32'd7);
    chk("rd_rdata", rd, 32'hDEADBEEF);
    chk("rd_resp", 32'(rs), 32'h0);
    chk("rd_timeout", 32'(to), 32'h0);
    r_lat = 0;

    // Timeout: AR never accepted
    ar_lat = -1;
    send_cmd(1'b0, 8'h20, 32'h0);
    n = 0;
    while (bus.m_axi_lite_arvalid === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_arvalid_cycles", 32'(n), 32'd16);
    wait_rsp(rd, rs, to, n);
    chk("to_resp", 32'(rs), 32'h2);
    chk("to_flag", 32'(to), 32'h1);
    chk("to_rdata", rd, 32'h0);
    ar_lat = 0; slv_rdata = 32'h12345678;
    send_cmd(1'b0, 8'h24, 32'h0);
    wait_rsp(rd, rs, to, n);
    chk("post_to_rdata", rd, 32'h12345678);
    chk("post_to_flag", 32'(to), 32'h0);

    // Response backpressure with a competing command offered
    rsp_ready = 1'b0; slv_rdata = 32'hCAFE0042;
    send_cmd(1'b0, 8'h2C, 32'h0);
    wait_rsp(rd, rs, to, n);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h3C; cmd_wdata = 32'h0BADF00D;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hCAFE0042);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'h0);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);

    // Reset while waiting for B
    b_lat = -1;
    send_cmd(1'b1, 8'h30, 32'h11112222);
    @(negedge clk);
    chk("rst_bready_before", 32'(bus.m_axi_lite_bready), 32'h1);
    axi_reset = 1'b1;
    @(negedge clk);
    axi_reset = 1'b0;
    chk("rst_bready_after", 32'(bus.m_axi_lite_bready), 32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    b_lat = 0;
    repeat (3) @(negedge clk);
    send_cmd(1'b1, 8'h34, 32'h5555AAAA);
    wait_rsp(rd, rs, to, n);
    chk("rst_next_latency", 32'(n), 32'd2);
    chk("rst_next_resp", 32'(rs), 32'h0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_lite_pz_master.md
Name: axi_lite_pz_master

Overview:
- AXI4-Lite initiator that drives the pole/zero register-file slave of the pixel generator from a simple command/response interface.
- Intended sources: a sweep/animation sequencer or a debug UART bridge, so pole/zero words can be updated without the PS.
- Handles one transaction at a time: write (AW+W, then B) or read (AR, then R).
- A timeout counter ensures a non-responding slave never hangs the requester.

Parameters:
- AXI_LITE_ADDR_WIDTH, 8, width of m_axi_lite_awaddr/araddr and cmd_addr.
- TIMEOUT_CYCLES, 1024, cycles allowed per transaction before an error is returned; 0 disables the timeout.

Ports:
- m_axi_lite_aclk  in  1  sole clock.
- axi_reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AXI_LITE_ADDR_WIDTH  byte address.
- cmd_wdata  in  32  write data, {re[15:0], im[15:0]} for pole/zero words.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  AXI response: 00 OK, 10 SLVERR; 10 is also used on timeout.
- rsp_timeout  out  1  response was generated by timeout.
- m_axi_lite_awaddr  out  AXI_LITE_ADDR_WIDTH
- m_axi_lite_awvalid  out  1
- m_axi_lite_awready  in  1
- m_axi_lite_wdata  out  32
- m_axi_lite_wstrb  out  4  constant 4'b1111.
- m_axi_lite_wvalid  out  1
- m_axi_lite_wready  in  1
- m_axi_lite_bresp  in  2
- m_axi_lite_bvalid  in  1
- m_axi_lite_bready  out  1
- m_axi_lite_araddr  out  AXI_LITE_ADDR_WIDTH
- m_axi_lite_arvalid  out  1
- m_axi_lite_arready  in  1
- m_axi_lite_rdata  in  32
- m_axi_lite_rresp  in  2
- m_axi_lite_rvalid  in  1
- m_axi_lite_rready  out  1

Behaviour:
- Reset (axi_reset = 1 at a clock edge):
  - State goes to IDLE.
  - All valid/ready outputs go to 0, except cmd_ready = 1.
  - rsp_rdata, rsp_resp and rsp_timeout go to 0; address/data registers go to 0.
  - Reset mid-transaction abandons it immediately; no response is emitted.
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid with cmd_write = 1: register address and data, raise awvalid and wvalid on the next cycle, go to WR_AW_W.
  - On cmd_valid with cmd_write = 0: register address, raise arvalid, go to RD_AR.
  - Command acceptance to first valid on AXI is exactly 1 cycle.
- WR_AW_W:
  - awvalid and wvalid each drop independently in the cycle after their own ready is sampled high.
  - Both may complete in the same cycle, or in either order.
  - Address and data stay stable while their valid is high.
  - When both are done, raise bready and go to WR_B.
- WR_B:
  - bready = 1.
  - On bvalid: capture bresp, set rsp_rdata = 0, go to RESP.
- RD_AR:
  - arvalid held until arready is high; then drop arvalid, raise rready, go to RD_R.
- RD_R:
  - rready = 1.
  - On rvalid: capture rdata and rresp, go to RESP.
- RESP:
  - rsp_valid = 1 and cmd_ready = 0.
  - On rsp_ready: go to IDLE, so cmd_ready is 1 in the following cycle.
- Valid handling: a valid is never withdrawn before its handshake completes, except on reset or timeout. Valids never depend combinationally on readies.
- Timeout:
  - The counter clears on command acceptance and increments every cycle in non-IDLE/non-RESP states.
  - When it reaches TIMEOUT_CYCLES: drop all AXI valid/ready outputs, set rsp_resp = 10, rsp_timeout = 1, rsp_rdata = 0, go to RESP.
- cmd_ready is combinational from state only.
- Throughput: minimum of 4 cycles per write when the slave is always ready (accept, AW/W, B, RESP).

Test Plan:
- Write to an always-ready slave: cmd write addr 0x04, data 0x0010FFF0 -> awaddr = 0x04 and wdata = 0x0010FFF0 with awvalid/wvalid high for 1 cycle; bresp 00 -> rsp_valid with rsp_resp = 00, rsp_rdata = 0.
- Skewed write: slave asserts wready 3 cycles before awready -> wvalid drops after its handshake; awvalid stays high with a stable address until awready; exactly one B is accepted.
- Read: cmd read addr 0x08, slave returns rdata 0xDEADBEEF, rresp 00 after 5 wait cycles -> rsp_rdata = 0xDEADBEEF, rsp_resp = 00, rsp_timeout = 0.
- Timeout with TIMEOUT_CYCLES = 16: slave never asserts arready -> arvalid drops at cycle 16; rsp_resp = 10, rsp_timeout = 1; next command accepted normally.
- Backpressure: rsp_ready held low 10 cycles -> rsp_valid and data held stable, cmd_ready = 0 throughout; no new AXI activity.
- Reset mid-operation: axi_reset during WR_B -> next cycle all valids/readies 0, cmd_ready = 1, no rsp_valid; a subsequent write completes correctly.
